// File: rtl/ram_arb_pkg.sv
// Shared types and defaults for the RAM port arbiter and its round-robin core.
// Optional lock/hold support is enabled with RAM_ARB_LOCK_EN.
package ram_arb_pkg;

   localparam int unsigned DefAddrW   = 13;
   localparam int unsigned DefDataW   = 32;
   localparam int unsigned DefMaxHold = 4;
   localparam int unsigned HoldCntW   = 4;

   typedef enum logic {
      GNT_M0 = 1'b0,
      GNT_M1 = 1'b1
   } grant_e;

   // Request bundle as presented to the RAM at default widths.
   typedef struct packed {
      logic [DefAddrW-1:0]   addr;
      logic [DefDataW/8-1:0] be;
      logic [DefDataW-1:0]   wdata;
      logic                  write;
   } ram_req_t;

endpackage

// File: rtl/ram_port_arbiter_rr_arb2.sv
// Two-way round-robin grant with last-grant memory; reusable for any shared slave.
// With RAM_ARB_LOCK_EN a locked requester may keep the grant up to MAX_HOLD cycles.
module rr_arb2
   import ram_arb_pkg::*;
#(
`ifdef RAM_ARB_LOCK_EN
   parameter int unsigned MAX_HOLD = DefMaxHold,
`endif
   parameter int unsigned NUM_REQ = 2
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic [NUM_REQ-1:0] req_i,
`ifdef RAM_ARB_LOCK_EN
   input  logic [NUM_REQ-1:0] lock_i,
`endif
   output logic               gnt_valid_o,
   output grant_e             gnt_o
);

   grant_e last_q, last_d;

`ifdef RAM_ARB_LOCK_EN
   localparam logic [HoldCntW-1:0] HoldMax = HoldCntW'(MAX_HOLD - 1);

   logic [HoldCntW-1:0] hold_cnt_q, hold_cnt_d;
   logic                keep_last;

   always_comb begin
      keep_last = lock_i[last_q] && (hold_cnt_q < HoldMax);
   end
`endif

   always_comb begin
      gnt_valid_o = 1'b0;
      gnt_o       = GNT_M0;
      if (req_i[0] && req_i[1]) begin
         gnt_valid_o = 1'b1;
         gnt_o       = (last_q == GNT_M0) ? GNT_M1 : GNT_M0;
`ifdef RAM_ARB_LOCK_EN
         if (keep_last) begin
            gnt_o = last_q;
         end
`endif
      end else if (req_i[0]) begin
         gnt_valid_o = 1'b1;
         gnt_o       = GNT_M0;
      end else if (req_i[1]) begin
         gnt_valid_o = 1'b1;
         gnt_o       = GNT_M1;
      end
   end

   always_comb begin
      last_d = gnt_valid_o ? gnt_o : last_q;
   end

`ifdef RAM_ARB_LOCK_EN
   // Saturate at HoldMax so an uncontested locked run still yields on the next contest.
   always_comb begin
      hold_cnt_d = hold_cnt_q;
      if (gnt_valid_o) begin
         if ((gnt_o == last_q) && lock_i[gnt_o]) begin
            hold_cnt_d = (hold_cnt_q < HoldMax) ? hold_cnt_q + 1'b1 : hold_cnt_q;
         end else begin
            hold_cnt_d = '0;
         end
      end
   end
`endif

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         last_q     <= GNT_M1;
`ifdef RAM_ARB_LOCK_EN
         hold_cnt_q <= '0;
`endif
      end else begin
         last_q     <= last_d;
`ifdef RAM_ARB_LOCK_EN
         hold_cnt_q <= hold_cnt_d;
`endif
      end
   end

endmodule

// File: rtl/ram_port_arbiter.sv
// Shares one single-port RAM between two Avalon-MM masters with round-robin grant
// and a one-cycle tagged read return. RAM_ARB_LOCK_EN adds m0_lock/m1_lock hold support.
module ram_port_arbiter
   import ram_arb_pkg::*;
#(
   parameter int unsigned ADDR_W = DefAddrW,
`ifdef RAM_ARB_LOCK_EN
   parameter int unsigned MAX_HOLD = DefMaxHold,
`endif
   parameter int unsigned DATA_W = DefDataW
) (
   input  logic                  clk,
   input  logic                  reset,

   input  logic [ADDR_W-1:0]     m0_address,
   input  logic [DATA_W/8-1:0]   m0_byteenable,
   input  logic                  m0_read,
   input  logic                  m0_write,
   input  logic [DATA_W-1:0]     m0_writedata,
   output logic                  m0_waitrequest,
   output logic [DATA_W-1:0]     m0_readdata,
   output logic                  m0_readdatavalid,
`ifdef RAM_ARB_LOCK_EN
   input  logic                  m0_lock,
`endif

   input  logic [ADDR_W-1:0]     m1_address,
   input  logic [DATA_W/8-1:0]   m1_byteenable,
   input  logic                  m1_read,
   input  logic                  m1_write,
   input  logic [DATA_W-1:0]     m1_writedata,
   output logic                  m1_waitrequest,
   output logic [DATA_W-1:0]     m1_readdata,
   output logic                  m1_readdatavalid,
`ifdef RAM_ARB_LOCK_EN
   input  logic                  m1_lock,
`endif

   output logic [ADDR_W-1:0]     ram_address,
   output logic [DATA_W/8-1:0]   ram_byteenable,
   output logic                  ram_chipselect,
   output logic                  ram_write,
   output logic [DATA_W-1:0]     ram_writedata,
   output logic                  ram_clken,
   input  logic [DATA_W-1:0]     ram_readdata
);

   localparam int unsigned BeW = DATA_W / 8;

   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic [BeW-1:0]    be;
      logic [DATA_W-1:0] wdata;
      logic              write;
   } req_bundle_t;

   logic        req0, req1;
   logic [1:0]  arb_req;
   logic        gnt_valid;
   grant_e      gnt;
   logic        rd_accept;

   req_bundle_t m0_bundle, m1_bundle, sel_bundle;
   req_bundle_t last_q, last_d;
   logic        rd_pend_q, rd_pend_d;
   grant_e      rd_tag_q, rd_tag_d;

   always_comb begin
      req0    = m0_read | m0_write;
      req1    = m1_read | m1_write;
      arb_req = reset ? 2'b00 : {req1, req0};
   end

   rr_arb2 #(
`ifdef RAM_ARB_LOCK_EN
      .MAX_HOLD    (MAX_HOLD),
`endif
      .NUM_REQ     (2)
   ) u_rr_arb2 (
      .clk_i       (clk),
      .rst_i       (reset),
      .req_i       (arb_req),
`ifdef RAM_ARB_LOCK_EN
      .lock_i      ({m1_lock, m0_lock}),
`endif
      .gnt_valid_o (gnt_valid),
      .gnt_o       (gnt)
   );

   // A simultaneous read+write is treated as a write: no read return is scheduled.
   always_comb begin
      m0_bundle  = '{addr: m0_address, be: m0_byteenable, wdata: m0_writedata, write: m0_write};
      m1_bundle  = '{addr: m1_address, be: m1_byteenable, wdata: m1_writedata, write: m1_write};
      sel_bundle = (gnt == GNT_M1) ? m1_bundle : m0_bundle;
      rd_accept  = gnt_valid & ~sel_bundle.write;
      last_d     = gnt_valid ? sel_bundle : last_q;
      rd_pend_d  = rd_accept;
      rd_tag_d   = rd_accept ? gnt : rd_tag_q;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         last_q    <= '0;
         rd_pend_q <= 1'b0;
         rd_tag_q  <= GNT_M0;
      end else begin
         last_q    <= last_d;
         rd_pend_q <= rd_pend_d;
         rd_tag_q  <= rd_tag_d;
      end
   end

   // Address/data hold the last granted values while the RAM is idle.
   always_comb begin
      ram_address    = gnt_valid ? sel_bundle.addr  : last_q.addr;
      ram_byteenable = gnt_valid ? sel_bundle.be    : last_q.be;
      ram_writedata  = gnt_valid ? sel_bundle.wdata : last_q.wdata;
      ram_chipselect = gnt_valid;
      ram_write      = gnt_valid & sel_bundle.write;
      ram_clken      = 1'b1;
   end

   always_comb begin
      m0_waitrequest   = reset | (req0 & ~(gnt_valid & (gnt == GNT_M0)));
      m1_waitrequest   = reset | (req1 & ~(gnt_valid & (gnt == GNT_M1)));
      m0_readdatavalid = rd_pend_q & (rd_tag_q == GNT_M0);
      m1_readdatavalid = rd_pend_q & (rd_tag_q == GNT_M1);
      m0_readdata      = ram_readdata;
      m1_readdata      = ram_readdata;
   end

endmodule
